hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline control counterpart to the EX stage slice.
- Tracks destination registers of in-flight instructions and produces the registered forwarding selects (fwd_reg0/fwd_reg1) that the EX stage consumes.
- Generates load-use stall and branch flush controls from the Branch signal that the EX stage emits.
- Sits beside the ID stage; its outputs are valid for the cycle in which the decoded instruction occupies EX.

Parameters:
- REG_W, 4, register specifier width.
- CNT_W, 16, width of the stall and flush event counters.
- ZERO_REG_FWD, 0, when 0 no forwarding or stall is generated for register 0; when 1 register 0 is treated like any other register.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  first source register (drives EX r0data)
- id_rt  in  REG_W  second source register (drives EX r1data)
- id_use_rs  in  1  instruction reads id_rs
- id_use_rt  in  1  instruction reads id_rt
- id_dst  in  REG_W  destination register
- id_regwrite  in  1  instruction writes id_dst
- id_memread  in  1  instruction is a load
- ex_branch  in  1  Branch from EX stage (taken branch resolved this cycle)
- fwd_reg0  out  2  registered EX operand-0 select: 00 regfile, 01 ALU_prv, 10 write_data_prvprv
- fwd_reg1  out  2  same encoding, for operand 1
- stall  out  1  hold PC and IF/ID this cycle; bubble into ID/EX
- flush  out  5  [0] clear IF/ID, [1] clear ID/EX, [4:2] always 0
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush events

Behaviour:
- Internal shadow state:
  - EX slot: ex_dst, ex_wr, ex_ld (instruction one ahead of ID).
  - MEM slot: mem_dst, mem_wr (instruction two ahead).
  - Every clock: MEM slot <= EX slot; EX slot <= ID fields or a bubble (all zero).
- Match rule: match_X(src) = X_wr & (X_dst == src) & use_src & id_valid & (ZERO_REG_FWD | src != 0).
- Load-use hazard: hz = match_EX(rs) & ex_ld, or the same for rt.
- Outputs are combinational from state and inputs:
  - stall = hz & ~ex_branch.
  - flush = {3'b000, ex_branch, ex_branch}.
- Forward select next value per operand:
  - 01 if match_EX.
  - else 10 if match_MEM.
  - else 00.
  - EX has priority over MEM when both match.
- Register update on clock edge:
  - If ex_branch or hz: EX slot <= bubble, fwd_reg0/fwd_reg1 <= 00.
  - Otherwise: EX slot <= {id_dst, id_regwrite & id_valid, id_memread & id_valid}, and fwd regs <= next selects.
- Load after one stall: the load moves to MEM and the waiting instruction re-evaluates. It gets 10 one cycle later, because the load sits in WB when the dependent instruction is in EX.
- Branch and hazard in the same cycle: ex_branch wins. stall = 0, flush[1:0] = 11, counts as a flush only.
- Regfile writes in the first half-cycle, so instructions three or more ahead need no forwarding.
- Counters:
  - stall_cnt +1 on each cycle with stall = 1.
  - flush_cnt +1 on each cycle with ex_branch = 1.
  - Both saturate at all-ones and do not wrap.
- Reset (rst low, asynchronous):
  - All shadow slots, fwd_reg0, fwd_reg1, stall_cnt and flush_cnt go to 0.
  - stall and flush evaluate to 0 because the slots are empty.
  - Reset asserted mid-stall cancels the bubble state; the first instruction after release sees no hazards.
- Latency: forwarding selects appear one clock after the instruction is in ID and stay valid for exactly that EX cycle.

Test Plan:
- ADD R3 in ID, next cycle SUB reading rs = R3 -> fwd_reg0 = 01 during SUB's EX; fwd_reg1 = 00.
- ADD R3, unrelated instruction, then XOR rt = R3 -> fwd_reg1 = 10 in XOR's EX; no stall.
- Load R5 then ADD rs = R5 -> stall = 1 for exactly one cycle, stall_cnt = 1, ADD's EX has fwd_reg0 = 10.
- Load R5 in EX with ex_branch = 1 while the dependent instruction is in ID -> stall = 0, flush = 5'b00011, flush_cnt = 1, next fwd selects 00.
- Writes to R0 followed by reads of R0 with ZERO_REG_FWD = 0 -> fwd selects stay 00, stall never asserted.
- Force 2^CNT_W + 3 stall cycles -> stall_cnt holds at 0xFFFF.
- Assert rst low mid-stream -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tracks in-flight destinations to produce registered EX forwarding selects,
// load-use stalls and branch flushes, with saturating event counters.
module hazard_fwd_unit #(
    parameter int REG_W        = 4,
    parameter int CNT_W        = 16,
    parameter int ZERO_REG_FWD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch,
    output logic [1:0]       fwd_reg0,
    output logic [1:0]       fwd_reg1,
    output logic             stall,
    output logic [4:0]       flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic [REG_W-1:0] ex_dst, mem_dst;
    logic             ex_wr, ex_ld, mem_wr;
    logic             rs_ok, rt_ok, ex_rs, ex_rt, mem_rs, mem_rt, hz;
    logic [1:0]       nxt0, nxt1;

    // rs_ok/rt_ok fold in validity, usage and the register-0 exemption
    assign rs_ok  = id_valid & id_use_rs & ((ZERO_REG_FWD != 0) | (id_rs != '0));
    assign rt_ok  = id_valid & id_use_rt & ((ZERO_REG_FWD != 0) | (id_rt != '0));
    assign ex_rs  = rs_ok & ex_wr  & (ex_dst  == id_rs);
    assign ex_rt  = rt_ok & ex_wr  & (ex_dst  == id_rt);
    assign mem_rs = rs_ok & mem_wr & (mem_dst == id_rs);
    assign mem_rt = rt_ok & mem_wr & (mem_dst == id_rt);
    assign hz     = (ex_rs | ex_rt) & ex_ld;
    assign stall  = hz & ~ex_branch;
    assign flush  = {3'b000, ex_branch, ex_branch};
    assign nxt0   = ex_rs ? 2'b01 : mem_rs ? 2'b10 : 2'b00;
    assign nxt1   = ex_rt ? 2'b01 : mem_rt ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_dst    <= '0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_dst   <= '0;
            mem_wr    <= 1'b0;
            fwd_reg0  <= 2'b00;
            fwd_reg1  <= 2'b00;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
            if (ex_branch || hz) begin
                ex_dst   <= '0;
                ex_wr    <= 1'b0;
                ex_ld    <= 1'b0;
                fwd_reg0 <= 2'b00;
                fwd_reg1 <= 2'b00;
            end else begin
                ex_dst   <= id_dst;
                ex_wr    <= id_regwrite & id_valid;
                ex_ld    <= id_memread & id_valid;
                fwd_reg0 <= nxt0;
                fwd_reg1 <= nxt1;
            end
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_branch && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed checks of forwarding, load-use stall, branch flush,
// register-0 handling, async reset and counter saturation (second instance has 4-bit counters).
module tb_hazard_fwd_unit;
    logic       clk, rst;
    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, ex_branch;
    logic [3:0] id_rs, id_rt, id_dst;
    logic [1:0] f0a, f1a, f0b, f1b;
    logic       sta, stb;
    logic [4:0] fla, flb;
    logic [15:0] sca, fca;
    logic [3:0]  scb, fcb;
    int n_vec = 0;
    int n_err = 0;

    hazard_fwd_unit dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch(ex_branch),
        .fwd_reg0(f0a), .fwd_reg1(f1a), .stall(sta), .flush(fla),
        .stall_cnt(sca), .flush_cnt(fca)
    );

    hazard_fwd_unit #(.REG_W(4), .CNT_W(4), .ZERO_REG_FWD(1)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch(ex_branch),
        .fwd_reg0(f0b), .fwd_reg1(f1b), .stall(stb), .flush(flb),
        .stall_cnt(scb), .flush_cnt(fcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input int dst, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = 4'(rs);
        id_rt       = 4'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_dst      = 4'(dst);
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        ex_branch = 1'b0;
        nop();
        rst = 1'b0;
        #1;
        chk("rst_fwd0", int'(f0a), 0);
        chk("rst_fwd1", int'(f1a), 0);
        chk("rst_stall", int'(sta), 0);
        chk("rst_flush", int'(fla), 0);
        chk("rst_scnt", int'(sca), 0);
        chk("rst_fcnt", int'(fca), 0);
        tick();
        tick();
        rst = 1'b1;
        // EX-distance forward
        set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
        set_id(1, 3, 4, 1, 1, 6, 1, 0);
        chk("ex_nostall", int'(sta), 0);
        tick();
        set_id(1, 7, 8, 1, 1, 9, 1, 0);
        chk("ex_fwd0", int'(f0a), 1);
        chk("ex_fwd1", int'(f1a), 0);
        tick();
        // MEM-distance forward
        set_id(1, 1, 1, 1, 1, 3, 1, 0);
        chk("unrel_fwd0", int'(f0a), 0);
        chk("unrel_fwd1", int'(f1a), 0);
        tick();
        set_id(1, 1, 2, 1, 1, 10, 1, 0); tick();
        set_id(1, 4, 3, 1, 1, 11, 1, 0);
        chk("mem_nostall", int'(sta), 0);
        tick();
        nop();
        chk("mem_fwd0", int'(f0a), 0);
        chk("mem_fwd1", int'(f1a), 2);
        tick();
        // EX beats MEM
        set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
        set_id(1, 3, 3, 1, 1, 12, 1, 0); tick();
        nop();
        chk("prio_fwd0", int'(f0a), 1);
        chk("prio_fwd1", int'(f1a), 1);
        tick();
        // load-use
        set_id(1, 1, 2, 1, 0, 5, 1, 1); tick();
        set_id(1, 5, 2, 1, 1, 6, 1, 0);
        chk("lu_stall", int'(sta), 1);
        chk("lu_flush", int'(fla), 0);
        tick();
        chk("lu_stall_gone", int'(sta), 0);
        chk("lu_scnt", int'(sca), 1);
        tick();
        nop();
        chk("lu_fwd0", int'(f0a), 2);
        chk("lu_fwd1", int'(f1a), 0);
        chk("lu_scnt_hold", int'(sca), 1);
        tick();
        // branch with a pending load-use hazard
        set_id(1, 1, 2, 1, 0, 5, 1, 1); tick();
        ex_branch = 1'b1;
        set_id(1, 5, 2, 1, 1, 6, 1, 0);
        chk("br_stall", int'(sta), 0);
        chk("br_flush", int'(fla), 3);
        tick();
        ex_branch = 1'b0;
        nop();
        chk("br_fcnt", int'(fca), 1);
        chk("br_scnt", int'(sca), 1);
        chk("br_fwd0", int'(f0a), 0);
        chk("br_fwd1", int'(f1a), 0);
        chk("br_flush_off", int'(fla), 0);
        tick();
        // register 0
        set_id(1, 1, 2, 1, 1, 0, 1, 0); tick();
        set_id(1, 0, 0, 1, 1, 7, 1, 0);
        chk("r0_nostall", int'(sta), 0);
        tick();
        set_id(1, 1, 2, 1, 1, 0, 1, 1);
        chk("r0_fwd0", int'(f0a), 0);
        chk("r0_fwd1", int'(f1a), 0);
        chk("r0z_fwd0", int'(f0b), 1);
        chk("r0z_fwd1", int'(f1b), 1);
        tick();
        set_id(1, 0, 2, 1, 1, 6, 1, 0);
        chk("r0_ld_nostall", int'(sta), 0);
        chk("r0z_ld_stall", int'(stb), 1);
        tick();
        // async reset during a stall
        set_id(1, 1, 2, 1, 0, 9, 1, 0); tick();
        set_id(1, 9, 2, 1, 0, 5, 1, 1); tick();
        set_id(1, 5, 2, 1, 0, 6, 1, 0);
        chk("pre_rst_stall", int'(sta), 1);
        chk("pre_rst_fwd0", int'(f0a), 1);
        chk("pre_rst_fcnt", int'(fca), 1);
        rst = 1'b0;
        #1;
        chk("arst_stall", int'(sta), 0);
        chk("arst_fwd0", int'(f0a), 0);
        chk("arst_scnt", int'(sca), 0);
        chk("arst_fcnt", int'(fca), 0);
        chk("arst_scnt_b", int'(scb), 0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_stall", int'(sta), 0);
        tick();
        nop();
        chk("post_rst_fwd0", int'(f0a), 0);
        // stall saturation: a stall every other cycle for 19 stalls
        set_id(1, 5, 2, 1, 0, 5, 1, 1);
        for (int k = 1; k <= 38; k++) begin
            chk("sat_stall", int'(sta), (k % 2 == 0) ? 1 : 0);
            tick();
        end
        chk("sat_scnt16", int'(sca), 19);
        chk("sat_scnt4", int'(scb), 15);
        // flush saturation
        ex_branch = 1'b1;
        #1;
        chk("satf_nostall", int'(sta), 0);
        for (int k = 1; k <= 17; k++) tick();
        chk("satf_fcnt16", int'(fca), 17);
        chk("satf_fcnt4", int'(fcb), 15);
        chk("satf_scnt16", int'(sca), 19);
        ex_branch = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
